// File: rtl/tile_place_executor.sv
// tile_place_executor
// Takes one tetromino request, reads the four board rows covered by the
// tile's 4x4 box through a synchronous row-memory port, checks for collision
// against occupied cells and the board edges, and then merges the tile into
// the board (mode 1) or erases it from the board (mode 2).
//
// Ports:
//   clk_i, reset_i      clock (rising edge), asynchronous active-low reset
//   v_i / ready_o       request handshake, accepted when v_i & ready_o
//   pos_x_i, pos_y_i    left column / top row of the tile's 4x4 box
//   shape_type_i        0=I 1=O 2=T 3=S 4=Z 5=J 6=L 7=invalid
//   rot_i               rotation 0..3, clockwise
//   mode_i              0=check 1=check-and-place 2=erase 3=check
//   read_addr_o         board row read address (data returns one cycle later)
//   read_data_i         board row data
//   write_v_o           row write strobe, with write_addr_o / write_data_o
//   done_v_o            one-cycle completion pulse
//   collide_o           result, held until the next accepted request
//
// Optional feature: define TILE_EXEC_EARLY_ABORT_EN to stop reading at the
// first detected collision and complete the cycle after that row's capture.

module tile_place_executor #(
  parameter int height_p = 32,
  parameter int width_p  = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        v_i,
  output logic                        ready_o,
  input  logic [$clog2(width_p)-1:0]  pos_x_i,
  input  logic [$clog2(height_p)-1:0] pos_y_i,
  input  logic [2:0]                  shape_type_i,
  input  logic [1:0]                  rot_i,
  input  logic [1:0]                  mode_i,
  output logic [$clog2(height_p)-1:0] read_addr_o,
  input  logic [width_p-1:0]          read_data_i,
  output logic                        write_v_o,
  output logic [$clog2(height_p)-1:0] write_addr_o,
  output logic [width_p-1:0]          write_data_o,
  output logic                        done_v_o,
  output logic                        collide_o
);

  localparam int XW = $clog2(width_p);
  localparam int YW = $clog2(height_p);

  typedef enum logic [1:0] {eIDLE, eREAD, eWRITE, eDONE} state_e;

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [XW-1:0]      pos_x_q;
  logic [YW-1:0]      pos_y_q;
  logic [1:0]         mode_q;
  logic [15:0]        mask_q;
  logic               collide_q;
  logic [width_p-1:0] row_buf [4];

  // SRS 4x4 boxes as {row3,row2,row1,row0}; bit c of a row is column pos_x+c.
  function automatic logic [15:0] shape_mask(input logic [2:0] s, input logic [1:0] r);
    logic [15:0] m;
    m = 16'h0000;
    case (s)
      3'd0: case (r)
        2'd0: m = {4'b0000, 4'b0000, 4'b1111, 4'b0000};
        2'd1: m = {4'b0100, 4'b0100, 4'b0100, 4'b0100};
        2'd2: m = {4'b0000, 4'b1111, 4'b0000, 4'b0000};
        default: m = {4'b0010, 4'b0010, 4'b0010, 4'b0010};
      endcase
      3'd1: m = {4'b0000, 4'b0000, 4'b0110, 4'b0110};
      3'd2: case (r)
        2'd0: m = {4'b0000, 4'b0000, 4'b0111, 4'b0010};
        2'd1: m = {4'b0000, 4'b0010, 4'b0110, 4'b0010};
        2'd2: m = {4'b0000, 4'b0010, 4'b0111, 4'b0000};
        default: m = {4'b0000, 4'b0010, 4'b0011, 4'b0010};
      endcase
      3'd3: case (r)
        2'd0: m = {4'b0000, 4'b0000, 4'b0011, 4'b0110};
        2'd1: m = {4'b0000, 4'b0100, 4'b0110, 4'b0010};
        2'd2: m = {4'b0000, 4'b0011, 4'b0110, 4'b0000};
        default: m = {4'b0000, 4'b0010, 4'b0011, 4'b0001};
      endcase
      3'd4: case (r)
        2'd0: m = {4'b0000, 4'b0000, 4'b0110, 4'b0011};
        2'd1: m = {4'b0000, 4'b0010, 4'b0110, 4'b0100};
        2'd2: m = {4'b0000, 4'b0110, 4'b0011, 4'b0000};
        default: m = {4'b0000, 4'b0001, 4'b0011, 4'b0010};
      endcase
      3'd5: case (r)
        2'd0: m = {4'b0000, 4'b0000, 4'b0111, 4'b0001};
        2'd1: m = {4'b0000, 4'b0010, 4'b0010, 4'b0110};
        2'd2: m = {4'b0000, 4'b0100, 4'b0111, 4'b0000};
        default: m = {4'b0000, 4'b0011, 4'b0010, 4'b0010};
      endcase
      3'd6: case (r)
        2'd0: m = {4'b0000, 4'b0000, 4'b0111, 4'b0100};
        2'd1: m = {4'b0000, 4'b0110, 4'b0010, 4'b0010};
        2'd2: m = {4'b0000, 4'b0001, 4'b0111, 4'b0000};
        default: m = {4'b0000, 4'b0010, 4'b0010, 4'b0011};
      endcase
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  // Mask row placed on the board; the top four bits are columns past the right edge.
  function automatic logic [width_p+3:0] shift_row(input logic [3:0] m, input logic [XW-1:0] x);
    return {{width_p{1'b0}}, m} << x;
  endfunction

  // Board row of box row r, one bit wider so rows past the bottom are visible.
  function automatic logic [YW:0] row_y(input logic [1:0] r);
    return {1'b0, pos_y_q} + (YW+1)'(r);
  endfunction

  logic               accept;
  logic               capture_v;
  logic [1:0]         cap_row;
  logic [3:0]         cap_mask;
  logic [YW:0]        cap_y;
  logic               cap_in;
  logic [width_p+3:0] cap_shift;
  logic               row_hit;
  logic [YW:0]        rd_y;
  logic [1:0]         wr_row;
  logic [3:0]         wr_mask;
  logic [YW:0]        wr_y;
  logic               wr_in;
  logic [width_p+3:0] wr_shift;

  // Collision check on the row whose data is arriving this cycle; the row
  // read when cnt was k is on read_data_i while cnt is k+1.
  always_comb begin
    accept    = v_i & ready_o;
    capture_v = (state_q == eREAD) && (cnt_q != 3'd0);
    cap_row   = cnt_q[1:0] - 2'd1;
    cap_mask  = mask_q[{cap_row, 2'b00} +: 4];
    cap_y     = row_y(cap_row);
    cap_in    = cap_y < (YW+1)'(height_p);
    cap_shift = shift_row(cap_mask, pos_x_q);
    row_hit   = capture_v && (mode_q != 2'd2) &&
                ((|cap_shift[width_p+3:width_p]) ||
                 (!cap_in && (|cap_mask)) ||
                 (cap_in && (|(cap_shift[width_p-1:0] & read_data_i))));
  end

  // Memory-facing outputs; rows past the bottom read address 0 and are never written.
  always_comb begin
    rd_y         = row_y(cnt_q[1:0]);
    wr_row       = cnt_q[1:0];
    wr_mask      = mask_q[{wr_row, 2'b00} +: 4];
    wr_y         = row_y(wr_row);
    wr_in        = wr_y < (YW+1)'(height_p);
    wr_shift     = shift_row(wr_mask, pos_x_q);
    ready_o      = (state_q == eIDLE) || (state_q == eDONE);
    done_v_o     = (state_q == eDONE);
    collide_o    = collide_q;
    read_addr_o  = '0;
    write_v_o    = 1'b0;
    write_addr_o = '0;
    write_data_o = '0;
    if ((state_q == eREAD) && !cnt_q[2] && (rd_y < (YW+1)'(height_p)))
      read_addr_o = rd_y[YW-1:0];
    if (state_q == eWRITE) begin
      write_v_o    = (|wr_mask) && wr_in;
      write_addr_o = wr_in ? wr_y[YW-1:0] : '0;
      write_data_o = (mode_q == 2'd2) ? (row_buf[wr_row] & ~wr_shift[width_p-1:0])
                                      : (row_buf[wr_row] |  wr_shift[width_p-1:0]);
    end
  end

  // Sequencing: four reads plus one extra cycle to capture the last row,
  // then either four write slots or straight to completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      eIDLE, eDONE: begin
        state_d = eIDLE;
        cnt_d   = 3'd0;
        if (accept)
          state_d = (shape_type_i == 3'd7) ? eDONE : eREAD;
      end
      eREAD: begin
        cnt_d = cnt_q + 3'd1;
`ifdef TILE_EXEC_EARLY_ABORT_EN
        if (row_hit) begin
          state_d = eDONE;
          cnt_d   = 3'd0;
        end else
`endif
        if (cnt_q == 3'd4) begin
          cnt_d = 3'd0;
          if ((mode_q == 2'd2) || ((mode_q == 2'd1) && !(collide_q | row_hit)))
            state_d = eWRITE;
          else
            state_d = eDONE;
        end
      end
      eWRITE: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          cnt_d   = 3'd0;
          state_d = eDONE;
        end
      end
      default: begin
        state_d = eIDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= eIDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch, row buffer and sticky collision flag.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      mode_q    <= 2'd0;
      mask_q    <= 16'h0000;
      collide_q <= 1'b0;
      for (int i = 0; i < 4; i++) row_buf[i] <= '0;
    end else begin
      if (accept) begin
        pos_x_q   <= pos_x_i;
        pos_y_q   <= pos_y_i;
        mode_q    <= mode_i;
        mask_q    <= shape_mask(shape_type_i, rot_i);
        collide_q <= (shape_type_i == 3'd7);
      end else if (row_hit) begin
        collide_q <= 1'b1;
      end
      if (capture_v)
        row_buf[cap_row] <= read_data_i;
    end
  end

endmodule

// File: tb/tb_tile_place_executor.sv
// tb_tile_place_executor
// Directed bench for tile_place_executor (16 columns x 32 rows) with a
// synchronous row memory model attached to the DUT's row ports.

module tb_tile_place_executor;

  logic        clk_i;
  logic        reset_i;
  logic        v_i;
  logic        ready_o;
  logic [3:0]  pos_x_i;
  logic [4:0]  pos_y_i;
  logic [2:0]  shape_type_i;
  logic [1:0]  rot_i;
  logic [1:0]  mode_i;
  logic [4:0]  read_addr_o;
  logic [15:0] read_data_i;
  logic        write_v_o;
  logic [4:0]  write_addr_o;
  logic [15:0] write_data_o;
  logic        done_v_o;
  logic        collide_o;

  logic [15:0] board [32];
  logic        ld_v;
  logic [4:0]  ld_addr;
  logic [15:0] ld_data;

  int tests_run;
  int tests_failed;
  int done_cycle;
  int collide_at_done;
  int wr_count;
  int wr_cycle [4];
  int wr_addr  [4];
  int wr_data  [4];

`ifdef TILE_EXEC_EARLY_ABORT_EN
  localparam bit early = 1'b1;
`else
  localparam bit early = 1'b0;
`endif

  tile_place_executor #(.height_p(32), .width_p(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .pos_x_i(pos_x_i), .pos_y_i(pos_y_i), .shape_type_i(shape_type_i),
    .rot_i(rot_i), .mode_i(mode_i), .read_addr_o(read_addr_o),
    .read_data_i(read_data_i), .write_v_o(write_v_o),
    .write_addr_o(write_addr_o), .write_data_o(write_data_o),
    .done_v_o(done_v_o), .collide_o(collide_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Board memory: one-cycle read latency, bench preload takes priority over DUT writes.
  always @(posedge clk_i) begin
    if (ld_v) board[ld_addr] <= ld_data;
    else if (write_v_o) board[write_addr_o] <= write_data_o;
    read_data_i <= board[read_addr_o];
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic loadRow(input int addr, input int data);
    @(negedge clk_i);
    ld_v    = 1'b1;
    ld_addr = 5'(addr);
    ld_data = 16'(data);
    @(posedge clk_i);
    #1 ld_v = 1'b0;
  endtask

  // Issue one request, then log every write and the completion cycle
  // (cycle 1 is the first cycle after the accepting edge).
  task automatic applyStimulus(input int shape, input int rot, input int x, input int y, input int mode);
    int waited;
    done_cycle      = 0;
    collide_at_done = -1;
    wr_count        = 0;
    waited          = 0;
    @(negedge clk_i);
    while (!ready_o && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    v_i          = 1'b1;
    shape_type_i = 3'(shape);
    rot_i        = 2'(rot);
    pos_x_i      = 4'(x);
    pos_y_i      = 5'(y);
    mode_i       = 2'(mode);
    @(posedge clk_i);
    #1 v_i = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_i);
      if (write_v_o && wr_count < 4) begin
        wr_cycle[wr_count] = n;
        wr_addr[wr_count]  = int'(write_addr_o);
        wr_data[wr_count]  = int'(write_data_o);
        wr_count++;
      end
      if (done_v_o) begin
        done_cycle      = n;
        collide_at_done = int'(collide_o);
        break;
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_i      = 1'b0;
    v_i          = 1'b0;
    pos_x_i      = '0;
    pos_y_i      = '0;
    shape_type_i = '0;
    rot_i        = '0;
    mode_i       = '0;
    ld_v         = 1'b0;
    ld_addr      = '0;
    ld_data      = '0;

    #3;
    $display("[TB] reset state");
    checkOutput("rst_ready", int'(ready_o), 1);
    checkOutput("rst_done", int'(done_v_o), 0);
    checkOutput("rst_write_v", int'(write_v_o), 0);
    checkOutput("rst_collide", int'(collide_o), 0);
    checkOutput("rst_read_addr", int'(read_addr_o), 0);
    checkOutput("rst_write_addr", int'(write_addr_o), 0);
    checkOutput("rst_write_data", int'(write_data_o), 0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b1;

    for (int r = 0; r < 32; r++) loadRow(r, 0);

    $display("[TB] O place on empty board");
    applyStimulus(1, 0, 4, 0, 1);
    checkOutput("A_collide", collide_at_done, 0);
    checkOutput("A_done_cycle", done_cycle, 10);
    checkOutput("A_wr_count", wr_count, 2);
    checkOutput("A_wr0_cycle", wr_cycle[0], 6);
    checkOutput("A_wr0_addr", wr_addr[0], 0);
    checkOutput("A_wr0_data", wr_data[0], 'h0060);
    checkOutput("A_wr1_addr", wr_addr[1], 1);
    checkOutput("A_wr1_data", wr_data[1], 'h0060);

    $display("[TB] O place onto occupied row 1");
    loadRow(0, 'h0000);
    loadRow(1, 'h0020);
    applyStimulus(1, 0, 4, 0, 1);
    checkOutput("B_collide", collide_at_done, 1);
    checkOutput("B_done_cycle", done_cycle, early ? 4 : 6);
    checkOutput("B_wr_count", wr_count, 0);
    @(negedge clk_i);
    checkOutput("B_done_pulse", int'(done_v_o), 0);
    checkOutput("B_collide_held", int'(collide_o), 1);

    $display("[TB] I rot0 past right edge");
    applyStimulus(0, 0, 13, 5, 0);
    checkOutput("C_collide", collide_at_done, 1);
    checkOutput("C_done_cycle", done_cycle, early ? 4 : 6);

    $display("[TB] bottom edge");
    applyStimulus(0, 1, 0, 30, 0);
    checkOutput("D_collide", collide_at_done, 1);
    checkOutput("D_done_cycle", done_cycle, early ? 5 : 6);
    applyStimulus(1, 2, 0, 30, 0);
    checkOutput("E_collide", collide_at_done, 0);
    checkOutput("E_done_cycle", done_cycle, 6);

    $display("[TB] O erase from full rows");
    loadRow(0, 'hFFFF);
    loadRow(1, 'hFFFF);
    applyStimulus(1, 0, 4, 0, 2);
    checkOutput("F_collide", collide_at_done, 0);
    checkOutput("F_done_cycle", done_cycle, 10);
    checkOutput("F_wr_count", wr_count, 2);
    checkOutput("F_wr0_data", wr_data[0], 'hFF9F);
    checkOutput("F_wr1_addr", wr_addr[1], 1);
    checkOutput("F_wr1_data", wr_data[1], 'hFF9F);

    $display("[TB] invalid shape");
    applyStimulus(7, 0, 0, 0, 1);
    checkOutput("G_collide", collide_at_done, 1);
    checkOutput("G_done_cycle", done_cycle, 1);
    checkOutput("G_wr_count", wr_count, 0);

    $display("[TB] T place, then recheck in modes 0 and 3");
    applyStimulus(2, 0, 2, 10, 1);
    checkOutput("H_collide", collide_at_done, 0);
    checkOutput("H_wr_count", wr_count, 2);
    checkOutput("H_wr0_addr", wr_addr[0], 10);
    checkOutput("H_wr0_data", wr_data[0], 'h0008);
    checkOutput("H_wr1_addr", wr_addr[1], 11);
    checkOutput("H_wr1_data", wr_data[1], 'h001C);
    checkOutput("H_wr1_cycle", wr_cycle[1], 7);
    applyStimulus(2, 0, 2, 10, 0);
    checkOutput("I_collide", collide_at_done, 1);
    checkOutput("I_done_cycle", done_cycle, early ? 3 : 6);
    applyStimulus(2, 0, 2, 10, 3);
    checkOutput("J_collide", collide_at_done, 1);
    checkOutput("J_wr_count", wr_count, 0);

    $display("[TB] reset during write phase");
    @(negedge clk_i);
    v_i          = 1'b1;
    shape_type_i = 3'd1;
    rot_i        = 2'd0;
    pos_x_i      = 4'd8;
    pos_y_i      = 5'd20;
    mode_i       = 2'd1;
    @(posedge clk_i);
    #1 v_i = 1'b0;
    for (int n = 0; n < 12 && !write_v_o; n++) @(negedge clk_i);
    checkOutput("K_write_seen", int'(write_v_o), 1);
    #2 reset_i = 1'b0;
    #1;
    checkOutput("K_write_v", int'(write_v_o), 0);
    checkOutput("K_ready", int'(ready_o), 1);
    checkOutput("K_done", int'(done_v_o), 0);
    checkOutput("K_collide", int'(collide_o), 0);
    checkOutput("K_write_addr", int'(write_addr_o), 0);
    checkOutput("K_write_data", int'(write_data_o), 0);
    checkOutput("K_read_addr", int'(read_addr_o), 0);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    checkOutput("K_idle_ready", int'(ready_o), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
